branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-stage dynamic branch predictor: direct-mapped branch target buffer (BTB) plus 2-bit
//  saturating counters. Combinationally predicts next PC for PCF; trained by the branch/jump
//  resolved in Execute. Raises mispredict + redirect PC, consumed by the hazard unit (flush of
//  FD/DE) and the PC mux (highest-priority next-PC source). Carries per-design perf counters.
// PARAMETERS
//  WIDTH    32  address/data width
//  ENTRIES  16  BTB entries, power of two, >=2; IDX = $clog2(ENTRIES)
// PORTS
//  clk             in   1      clock, all state on rising edge
//  rst             in   1      asynchronous, active-high reset
//  PCF             in   WIDTH  fetch PC (lookup address)
//  PredTakenF      out  1      predict taken for PCF
//  PredTargetF     out  WIDTH  predicted target (PCF+4 when PredTakenF=0)
//  ResolveE        in   1      Execute holds a branch or jump (BranchE|JumpE)
//  JumpE           in   1      Execute instr is JAL/JALR (always taken)
//  TakenE          in   1      actual outcome (branch condition true, or JumpE)
//  PCE             in   WIDTH  PC of Execute instr
//  TargetE         in   WIDTH  actual target computed in Execute
//  PCPlus4E        in   WIDTH  fall-through of Execute instr
//  PredTakenE      in   1      PredTakenF piped F->D->E (cleared by flush)
//  PredTargetE     in   WIDTH  PredTargetF piped F->D->E
//  MispredictE     out  1      redirect required this cycle
//  RedirectPCE     out  WIDTH  correct next PC when MispredictE=1, else 0
//  BranchCount     out  32     resolved branches/jumps since reset
//  MispredCount    out  32     mispredictions since reset
// BEHAVIOUR
//  - idx = PC[IDX+1:2]; tag = PC[WIDTH-1:IDX+2]. Entry = {valid, tag, target, ctr[1:0]}.
//  - Lookup (combinational, 0 latency): hit = valid[idx] && tag match;
//    PredTakenF = hit && ctr[1]; PredTargetF = PredTakenF ? target : PCF+4.
//  - Mispredict (combinational on E inputs):
//    ResolveE: Mispredict = (TakenE!=PredTakenE) | (TakenE & PredTargetE!=TargetE);
//              RedirectPCE = TakenE ? TargetE : PCPlus4E.
//    !ResolveE & PredTakenE (stale/aliased entry): Mispredict=1, RedirectPCE=PCPlus4E.
//    Otherwise Mispredict=0, RedirectPCE=0.
//  - Update (rising edge, at PCE's idx), written state visible to lookup next cycle:
//    taken, entry hit: target<=TargetE; ctr<=sat_inc(ctr) (11 stays 11).
//    taken, miss: allocate valid=1, tag, target<=TargetE, ctr<=10 (weak taken) — replaces.
//    not taken, hit: ctr<=sat_dec(ctr) (00 stays 00); entry stays valid.
//    not taken, miss: no change.
//    JumpE: ctr<=11 regardless of prior state.
//    !ResolveE & PredTakenE: valid[idx]<=0.
//  - Same-cycle lookup and update of same idx: lookup sees OLD contents (no bypass).
//  - Counters: BranchCount +1 on ResolveE; MispredCount +1 on MispredictE; both saturate at
//    32'hFFFF_FFFF (no wrap).
//  - Reset: all valid<=0, all ctr<=01, targets/tags<=0, both counters<=0. Reset mid-run
//    discards all history; outputs immediately PredTakenF=0, PredTargetF=PCF+4.
//  - Pipeline stall does not gate updates: a stalled E is already a bubble (ResolveE=0,
//    PredTakenE=0). Flush of E stage is the caller's responsibility.
//  - PCF/PCE low bits [1:0] ignored; arithmetic on PCF+4 wraps modulo 2^WIDTH.
// STRUCTURE
//  - bp_pkg: typedef enum logic[1:0] {SNT=00, WNT=01, WT=10, ST=11} bp_ctr_t; BP_CTR_RESET=WNT,
//    BP_CTR_ALLOC=WT; typedef struct for BTB entry (parameterised widths via localparams).
//  - One sub-module: bp_sat_counter (2-bit next-state: inc/dec/force-strong), instanced per
//    update path, pure combinational. BTB array and perf counters live in top of block.
// TESTING
//  1 Reset, PCF=0x100 -> PredTakenF=0, PredTargetF=0x104, counts 0.
//  2 Branch PCE=0x100 taken to 0x80, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x80;
//    next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80 (ctr=WT).
//  3 Same branch not-taken twice -> ctr WT->WNT->SNT; PredTakenF=0; second resolve with
//    PredTakenE=0 -> MispredictE=0; MispredCount increments only on the first.
//  4 Alias: ENTRIES=16, allocate 0x100, then taken branch at 0x140 (same idx) -> entry replaced;
//    PCF=0x100 misses; !ResolveE with PredTakenE=1 at PCE=0x100 -> redirect 0x104, valid cleared.
//  5 JALR PCE=0x200, TargetE=0x300 then 0x340 with PredTargetE=0x300 -> 2nd MispredictE=1,
//    RedirectPCE=0x340, stored target updates to 0x340, ctr=ST.
//  6 Assert rst mid-sequence after 5 -> all predictions not-taken next cycle, counters 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Branch predictor shared types.
//   bp_ctr_t   : 2-bit saturating direction counter encoding
//   bp_entry_t : one BTB entry {valid, tag, target, ctr}
//   sat_inc32  : saturating increment used by the perf counters
package bp_pkg;

  localparam int BP_WIDTH   = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_IDX     = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_WIDTH - BP_IDX - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t BP_CTR_RESET = WNT;
  localparam bp_ctr_t BP_CTR_ALLOC = WT;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_WIDTH-1:0] target;
    bp_ctr_t             ctr;
  } bp_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state (pure combinational).
//   ctr_i    : current counter
//   inc_i    : step towards strongly taken (saturates at ST)
//   dec_i    : step towards strongly not-taken (saturates at SNT)
//   strong_i : force ST, overrides inc/dec (unconditional jumps)
//   ctr_o    : next counter value
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       strong_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (strong_i)                         ctr_o = ST;
    else if (inc_i && ctr_i != 2'(ST))    ctr_o = ctr_i + 2'd1;
    else if (dec_i && ctr_i != 2'(SNT))   ctr_o = ctr_i - 2'd1;
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped BTB with 2-bit counters.
//   clk, rst                 : clock, async active-high reset
//   PCF                      : fetch PC; PredTakenF/PredTargetF predict its next PC
//   ResolveE/JumpE/TakenE    : Execute-stage branch/jump resolution
//   PCE/TargetE/PCPlus4E     : Execute PC, actual target, fall-through
//   PredTakenE/PredTargetE   : prediction made for the Execute instruction
//   MispredictE/RedirectPCE  : redirect request and correct next PC
//   BranchCount/MispredCount : saturating perf counters
// Parameters must match the bp_pkg entry layout (WIDTH/ENTRIES defaults).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int WIDTH   = BP_WIDTH,
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PCF,
  output logic             PredTakenF,
  output logic [WIDTH-1:0] PredTargetF,
  input  logic             ResolveE,
  input  logic             JumpE,
  input  logic             TakenE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] TargetE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic             PredTakenE,
  input  logic [WIDTH-1:0] PredTargetE,
  output logic             MispredictE,
  output logic [WIDTH-1:0] RedirectPCE,
  output logic [31:0]      BranchCount,
  output logic [31:0]      MispredCount
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;

  bp_entry_t btb_q [ENTRIES];
  bp_entry_t entry_d;
  logic      we_d;
  logic [31:0] bcnt_q, mcnt_q;

  logic [IDX-1:0]   idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic [1:0]       ctr_cur, ctr_nxt;

  // PC[1:0] never affects indexing or tags
  logic unused_lowbits;
  assign unused_lowbits = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[IDX+1:2];
  assign tag_f = PCF[WIDTH-1:IDX+2];
  assign idx_e = PCE[IDX+1:2];
  assign tag_e = PCE[WIDTH-1:IDX+2];

  // Lookup reads registered state only, so a same-cycle update is not seen
  assign hit_f       = btb_q[idx_f].valid && (btb_q[idx_f].tag == tag_f);
  assign PredTakenF  = hit_f && btb_q[idx_f].ctr[1];
  assign PredTargetF = PredTakenF ? btb_q[idx_f].target : PCF + WIDTH'(4);

  assign hit_e = btb_q[idx_e].valid && (btb_q[idx_e].tag == tag_e);

  always_comb begin
    MispredictE = 1'b0;
    RedirectPCE = '0;
    if (ResolveE) begin
      MispredictE = (TakenE != PredTakenE) || (TakenE && (PredTargetE != TargetE));
      if (MispredictE) RedirectPCE = TakenE ? TargetE : PCPlus4E;
    end else if (PredTakenE) begin
      // predicted taken on something that is not a branch: stale or aliased entry
      MispredictE = 1'b1;
      RedirectPCE = PCPlus4E;
    end
  end

  // A miss feeds the allocation value in with no increment, so a fresh entry
  // lands on WT (or ST when the strong override fires for a jump).
  assign ctr_cur = hit_e ? btb_q[idx_e].ctr : BP_CTR_ALLOC;

  bp_sat_counter u_ctr (
    .ctr_i    (ctr_cur),
    .inc_i    (TakenE && hit_e),
    .dec_i    (!TakenE),
    .strong_i (JumpE),
    .ctr_o    (ctr_nxt)
  );

  always_comb begin
    entry_d = btb_q[idx_e];
    we_d    = 1'b0;
    if (ResolveE) begin
      if (TakenE) begin
        we_d           = 1'b1;
        entry_d.valid  = 1'b1;
        entry_d.tag    = tag_e;
        entry_d.target = TargetE;
        entry_d.ctr    = bp_ctr_t'(ctr_nxt);
      end else if (hit_e) begin
        we_d        = 1'b1;
        entry_d.ctr = bp_ctr_t'(ctr_nxt);
      end
    end else if (PredTakenE) begin
      we_d          = 1'b1;
      entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i].valid  <= 1'b0;
        btb_q[i].tag    <= '0;
        btb_q[i].target <= '0;
        btb_q[i].ctr    <= BP_CTR_RESET;
      end
    end else if (we_d) begin
      btb_q[idx_e] <= entry_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (ResolveE)    bcnt_q <= sat_inc32(bcnt_q);
      if (MispredictE) mcnt_q <= sat_inc32(mcnt_q);
    end
  end

  assign BranchCount  = bcnt_q;
  assign MispredCount = mcnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PredTargetF, PCE, TargetE, PCPlus4E, PredTargetE, RedirectPCE;
  logic [31:0] BranchCount, MispredCount;
  logic        PredTakenF, ResolveE, JumpE, TakenE, PredTakenE, MispredictE;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .ResolveE(ResolveE), .JumpE(JumpE), .TakenE(TakenE), .PCE(PCE), .TargetE(TargetE),
    .PCPlus4E(PCPlus4E), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  typedef struct {
    logic [31:0] pcf;
    logic        res, jmp, tkn;
    logic [31:0] pce, tgt, p4;
    logic        pte;
    logic [31:0] ptge;
    logic        ept;
    logic [31:0] eptg;
    logic        emis;
    logic [31:0] ered;
    logic        chkred;
    logic [31:0] ebc, emc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] pcf, logic res, jmp, tkn, logic [31:0] pce, tgt, p4,
                              logic pte, logic [31:0] ptge, logic ept, logic [31:0] eptg,
                              logic emis, logic [31:0] ered, logic chkred, logic [31:0] ebc, emc);
    vec_t v;
    v.pcf = pcf; v.res = res; v.jmp = jmp; v.tkn = tkn; v.pce = pce; v.tgt = tgt; v.p4 = p4;
    v.pte = pte; v.ptge = ptge; v.ept = ept; v.eptg = eptg; v.emis = emis; v.ered = ered;
    v.chkred = chkred; v.ebc = ebc; v.emc = emc;
    return v;
  endfunction

  function automatic vec_t idle(logic [31:0] pcf, logic ept, logic [31:0] eptg, logic [31:0] ebc, emc);
    return mk(pcf, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, ept, eptg, 0, 32'h0, 1, ebc, emc);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    PCF = v.pcf; ResolveE = v.res; JumpE = v.jmp; TakenE = v.tkn; PCE = v.pce;
    TargetE = v.tgt; PCPlus4E = v.p4; PredTakenE = v.pte; PredTargetE = v.ptge;
  endtask

  task automatic check_outs(string tag, vec_t v);
    chk({tag, ".PredTakenF"},  32'(PredTakenF),  32'(v.ept));
    chk({tag, ".PredTargetF"}, PredTargetF,      v.eptg);
    chk({tag, ".MispredictE"}, 32'(MispredictE), 32'(v.emis));
    if (v.chkred) chk({tag, ".RedirectPCE"}, RedirectPCE, v.ered);
    chk({tag, ".BranchCount"}, BranchCount,      v.ebc);
    chk({tag, ".MispredCount"}, MispredCount,    v.emc);
  endtask

  initial begin
    // Each vector: inputs held for one cycle, outputs checked before the
    // updating edge (lookup shows state from previous edges).
    vecs.push_back(idle(32'h100, 0, 32'h104, 0, 0));
    vecs.push_back(mk(32'h100, 1,0,1, 32'h100, 32'h80, 32'h104, 0, 32'h104, 0, 32'h104, 1, 32'h80, 1, 0, 0));
    vecs.push_back(idle(32'h100, 1, 32'h80, 1, 1));
    vecs.push_back(mk(32'h100, 1,0,0, 32'h100, 32'h80, 32'h104, 1, 32'h80, 1, 32'h80, 1, 32'h104, 1, 1, 1));
    vecs.push_back(mk(32'h100, 1,0,0, 32'h100, 32'h80, 32'h104, 0, 32'h104, 0, 32'h104, 0, 32'h0, 0, 2, 2));
    vecs.push_back(idle(32'h100, 0, 32'h104, 3, 2));
    vecs.push_back(mk(32'h140, 1,0,1, 32'h140, 32'h40, 32'h144, 0, 32'h144, 0, 32'h144, 1, 32'h40, 1, 3, 2));
    vecs.push_back(idle(32'h100, 0, 32'h104, 4, 3));
    vecs.push_back(mk(32'h140, 0,0,0, 32'h100, 32'h0, 32'h104, 1, 32'h80, 1, 32'h40, 1, 32'h104, 1, 4, 3));
    vecs.push_back(idle(32'h140, 0, 32'h144, 4, 4));
    vecs.push_back(mk(32'h200, 1,1,1, 32'h200, 32'h300, 32'h204, 0, 32'h204, 0, 32'h204, 1, 32'h300, 1, 4, 4));
    vecs.push_back(mk(32'h200, 1,1,1, 32'h200, 32'h340, 32'h204, 1, 32'h300, 1, 32'h300, 1, 32'h340, 1, 5, 5));
    vecs.push_back(idle(32'h200, 1, 32'h340, 6, 6));
    vecs.push_back(mk(32'h200, 1,0,0, 32'h200, 32'h340, 32'h204, 1, 32'h340, 1, 32'h340, 1, 32'h204, 1, 6, 6));
    vecs.push_back(idle(32'h200, 1, 32'h340, 7, 7));
    vecs.push_back(idle(32'hFFFF_FFFC, 0, 32'h0, 7, 7));
    vecs.push_back(idle(32'h202, 1, 32'h340, 7, 7));

    rst = 1'b1;
    drive(idle(32'h100, 0, 32'h104, 0, 0));
    #1;
    check_outs("reset", idle(32'h100, 0, 32'h104, 0, 0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    // Asynchronous reset mid-run: history and counters gone immediately
    drive(idle(32'h200, 0, 32'h204, 0, 0));
    rst = 1'b1;
    #1;
    check_outs("rst_async", idle(32'h200, 0, 32'h204, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs("rst_after", idle(32'h200, 0, 32'h204, 0, 0));
    @(negedge clk);
    // Fresh jump after reset allocates again and counts from zero
    drive(mk(32'h200, 1,1,1, 32'h200, 32'h300, 32'h204, 0, 32'h204, 0, 32'h204, 1, 32'h300, 1, 0, 0));
    #1;
    check_outs("post_rst_jmp", mk(32'h200, 1,1,1, 32'h200, 32'h300, 32'h204, 0, 32'h204, 0, 32'h204, 1, 32'h300, 1, 0, 0));
    @(negedge clk);
    drive(idle(32'h200, 1, 32'h300, 1, 1));
    #1;
    check_outs("post_rst_hit", idle(32'h200, 1, 32'h300, 1, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
